instruction_fetch_stage: RTL and testbench

Fetch stage that sits directly upstream of the instruction memory. It owns the program counter and drives the byte address into the memory. It captures each returned 32-bit instruction with its PC into a 2-entry fetch buffer, which it presents to the decode stage over a valid/ready handshake. Taken branches redirect the PC and flush everything already fetched.

---
 rtl/instruction_fetch_stage_if.sv | 39 +++
 rtl/instruction_fetch_stage.sv | 100 ++++++++++
 tb/tb_instruction_fetch_stage.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bus: instruction-memory address/data, execute redirect and the
// valid/ready handoff of {PC, instruction} to decode.
interface instruction_fetch_stage_if #(
  parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] o_Address;
    logic [DATA_WIDTH-1:0] i_Instruction;
    logic                  i_Branch_Taken;
    logic [DATA_WIDTH-1:0] i_Branch_Target;
    logic                  o_Valid;
    logic                  i_Ready;
    logic [DATA_WIDTH-1:0] o_Instruction;
    logic [DATA_WIDTH-1:0] o_PC;
    logic                  o_Fault;

    modport master (
        output o_Address,
        input  i_Instruction,
        input  i_Branch_Taken,
        input  i_Branch_Target,
        output o_Valid,
        input  i_Ready,
        output o_Instruction,
        output o_PC,
        output o_Fault
    );

    modport slave (
        input  o_Address,
        output i_Instruction,
        output i_Branch_Taken,
        output i_Branch_Target,
        input  o_Valid,
        output i_Ready,
        input  o_Instruction,
        input  o_PC,
        input  o_Fault
    );
endinterface

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC, captures {PC, instruction} into a 2-entry buffer for decode.
// Optional misaligned-redirect fault/halt enabled by defining FETCH_ALIGN_CHECK_EN.
module instruction_fetch_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    instruction_fetch_stage_if.master   bus
);

    function automatic logic [DATA_WIDTH-1:0] word_align(input logic [DATA_WIDTH-1:0] addr);
        return addr & ~DATA_WIDTH'(3);
    endfunction

    logic [DATA_WIDTH-1:0] pc_q;
    logic [1:0]            count_q;
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [DATA_WIDTH-1:0] buf_pc_q    [2];
    logic [DATA_WIDTH-1:0] buf_instr_q [2];

    logic                  pop;
    logic                  fetch;
    logic                  redirect;
    logic                  halted;
    logic                  valid;
    logic [DATA_WIDTH-1:0] redirect_pc;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q;
    logic misaligned;

    assign misaligned  = |bus.i_Branch_Target[1:0];
    assign redirect_pc = bus.i_Branch_Target;
    assign halted      = fault_q;

    // Fault is sticky; once set the stage ignores everything until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_q <= 1'b0;
        end else if (redirect && misaligned) begin
            fault_q <= 1'b1;
        end
    end

    assign bus.o_Fault = fault_q;
`else
    assign redirect_pc = word_align(bus.i_Branch_Target);
    assign halted      = 1'b0;
    assign bus.o_Fault = 1'b0;
`endif

    assign valid    = (count_q != 2'd0);
    assign pop      = valid & bus.i_Ready;
    assign redirect = bus.i_Branch_Taken & ~halted;
    assign fetch    = ((count_q != 2'd2) | pop) & ~bus.i_Branch_Taken & ~halted;

    // Control state: PC, occupancy and pointers; redirect overrides fetch/pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else if (redirect) begin
            pc_q     <= redirect_pc;
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (fetch) begin
                pc_q     <= pc_q + DATA_WIDTH'(4);
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({fetch, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Buffer payload carries no reset; empty entries are masked at the output.
    always_ff @(posedge clk) begin
        if (fetch) begin
            buf_pc_q[wr_ptr_q]    <= pc_q;
            buf_instr_q[wr_ptr_q] <= bus.i_Instruction;
        end
    end

    assign bus.o_Address     = pc_q;
    assign bus.o_Valid       = valid;
    assign bus.o_Instruction = valid ? buf_instr_q[rd_ptr_q] : '0;
    assign bus.o_PC          = valid ? buf_pc_q[rd_ptr_q]    : '0;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with a combinational instruction memory model.
module tb_instruction_fetch_stage;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    instruction_fetch_stage_if #(.DATA_WIDTH(32)) bus ();

    instruction_fetch_stage #(
        .DATA_WIDTH (32),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Memory: MOV R0,#20 at address 0, elsewhere a tag derived from the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'hE3A0_0014 : (32'hA000_0000 ^ a);
    endfunction

    always_comb bus.i_Instruction = mem_word(bus.o_Address);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        bus.i_Ready         = 1'b1;
        bus.i_Branch_Taken  = 1'b0;
        bus.i_Branch_Target = 32'h0;
        #2;
        check_eq("rst_addr",  bus.o_Address,     32'h0);
        check_eq("rst_valid", 32'(bus.o_Valid),  32'h0);
        check_eq("rst_instr", bus.o_Instruction, 32'h0);
        check_eq("rst_pc",    bus.o_PC,          32'h0);
        check_eq("rst_fault", 32'(bus.o_Fault),  32'h0);

        // Streaming with decode always ready
        do_reset();
        check_eq("s0_addr",  bus.o_Address,    32'h0);
        check_eq("s0_valid", 32'(bus.o_Valid), 32'h0);
        step();
        check_eq("s1_valid", 32'(bus.o_Valid), 32'h1);
        check_eq("s1_pc",    bus.o_PC,          32'h0);
        check_eq("s1_instr", bus.o_Instruction, 32'hE3A0_0014);
        check_eq("s1_addr",  bus.o_Address,     32'h4);
        step();
        check_eq("s2_pc",    bus.o_PC,          32'h4);
        check_eq("s2_instr", bus.o_Instruction, 32'hA000_0004);
        check_eq("s2_addr",  bus.o_Address,     32'h8);
        step();
        check_eq("s3_pc",    bus.o_PC,          32'h8);
        check_eq("s3_addr",  bus.o_Address,     32'hC);

        // Backpressure fills the buffer, then drains with no gap
        bus.i_Ready = 1'b0;
        do_reset();
        for (int i = 0; i < 5; i++) step();
        check_eq("bp_addr",  bus.o_Address,    32'h8);
        check_eq("bp_valid", 32'(bus.o_Valid), 32'h1);
        check_eq("bp_pc",    bus.o_PC,         32'h0);
        bus.i_Ready = 1'b1;
        step();
        check_eq("dr1_pc",   bus.o_PC,      32'h4);
        check_eq("dr1_addr", bus.o_Address, 32'hC);
        step();
        check_eq("dr2_pc",   bus.o_PC,      32'h8);
        check_eq("dr2_addr", bus.o_Address, 32'h10);

        // Redirect from a full buffer with a same-cycle pop
        bus.i_Ready = 1'b0;
        step();
        step();
        check_eq("full_pc", bus.o_PC, 32'h8);
        bus.i_Ready         = 1'b1;
        bus.i_Branch_Taken  = 1'b1;
        bus.i_Branch_Target = 32'h14;
        step();
        bus.i_Branch_Taken = 1'b0;
        check_eq("br1_valid", 32'(bus.o_Valid), 32'h0);
        check_eq("br1_addr",  bus.o_Address,    32'h14);
        step();
        check_eq("br2_valid", 32'(bus.o_Valid), 32'h1);
        check_eq("br2_pc",    bus.o_PC,          32'h14);
        check_eq("br2_instr", bus.o_Instruction, 32'hA000_0014);

        // Held redirect: last target wins
        bus.i_Branch_Taken  = 1'b1;
        bus.i_Branch_Target = 32'h40;
        step();
        bus.i_Branch_Target = 32'h80;
        step();
        check_eq("hold_addr",  bus.o_Address,    32'h80);
        check_eq("hold_valid", 32'(bus.o_Valid), 32'h0);
        bus.i_Branch_Taken = 1'b0;
        step();
        check_eq("hold_pc", bus.o_PC, 32'h80);

        // Asynchronous reset with a full buffer
        bus.i_Ready = 1'b0;
        step();
        step();
        check_eq("pre_rst_valid", 32'(bus.o_Valid), 32'h1);
        reset = 1'b1;
        #1;
        check_eq("arst_valid", 32'(bus.o_Valid), 32'h0);
        check_eq("arst_addr",  bus.o_Address,    32'h0);
        step();
        reset       = 1'b0;
        bus.i_Ready = 1'b1;

        // PC wrap at the top of the address space
        bus.i_Branch_Taken  = 1'b1;
        bus.i_Branch_Target = 32'hFFFF_FFFC;
        step();
        bus.i_Branch_Taken = 1'b0;
        check_eq("wrap_addr0", bus.o_Address, 32'hFFFF_FFFC);
        step();
        check_eq("wrap_pc",    bus.o_PC,         32'hFFFF_FFFC);
        check_eq("wrap_addr",  bus.o_Address,    32'h0);
        check_eq("wrap_fault", 32'(bus.o_Fault), 32'h0);

        // Misaligned redirect target
        bus.i_Branch_Taken  = 1'b1;
        bus.i_Branch_Target = 32'h16;
        step();
        bus.i_Branch_Taken = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        check_eq("mis_fault", 32'(bus.o_Fault), 32'h1);
        check_eq("mis_addr",  bus.o_Address,    32'h16);
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("mis_valid", 32'(bus.o_Valid), 32'h0);
        end
        check_eq("mis_hold_addr", bus.o_Address, 32'h16);
        do_reset();
        check_eq("mis_rst_fault", 32'(bus.o_Fault), 32'h0);
`else
        check_eq("mis_addr",  bus.o_Address,    32'h14);
        check_eq("mis_fault", 32'(bus.o_Fault), 32'h0);
        step();
        check_eq("mis_pc",    bus.o_PC,         32'h14);
        check_eq("mis_valid", 32'(bus.o_Valid), 32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
